// File: rtl/prefix8_adder.sv
// prefix8_adder: 8-bit Kogge-Stone parallel-prefix adder for a TinyTapeout slot.
// uo_out = (ui_in + uio_in) mod 256. Carry-in is fixed at 0, and carry-out is dropped.
// Optional build macro PIPELINE_REG_EN: registers the operands and the sum,
// giving 2 cycles of latency. Without it, the block is purely combinational.
module prefix8_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] uo_out,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe
);

  // Operands that feed the prefix network (raw pins or registered copies)
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;

  // Bit-level generate/propagate and the three Kogge-Stone levels
  logic [WIDTH-1:0] g0, p0;
  logic [WIDTH-1:0] g1, p1;
  logic [WIDTH-1:0] g2, p2;
  logic [WIDTH-1:0] g3, p3;

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sumComb;
  logic             cout;

  // Prefix operator: (G,P) o (G',P') = (G | P&G', P&P'), returned as {G,P}
  function automatic logic [1:0] prefixOp(input logic gHi, input logic pHi,
                                          input logic gLo, input logic pLo);
    return {gHi | (pHi & gLo), pHi & pLo};
  endfunction

  // Bit generate/propagate from the two operands
  always_comb begin
    g0 = opA & opB;
    p0 = opA ^ opB;
  end

  // Level 1: span 1. Bit 0 has no lower neighbour, so it passes through.
  always_comb begin
    g1 = g0;
    p1 = p0;
    for (int i = 1; i < WIDTH; i++) begin
      {g1[i], p1[i]} = prefixOp(g0[i], p0[i], g0[i-1], p0[i-1]);
    end
  end

  // Level 2: span 2. Bits 0-1 already cover their full prefix.
  always_comb begin
    g2 = g1;
    p2 = p1;
    for (int i = 2; i < WIDTH; i++) begin
      {g2[i], p2[i]} = prefixOp(g1[i], p1[i], g1[i-2], p1[i-2]);
    end
  end

  // Level 3: span 4. After this level, g3[i] is the group generate G[i:0].
  always_comb begin
    g3 = g2;
    p3 = p2;
    for (int i = 4; i < WIDTH; i++) begin
      {g3[i], p3[i]} = prefixOp(g2[i], p2[i], g2[i-4], p2[i-4]);
    end
  end

  // Carries come straight from the group generates (carry-in is 0). Sum = p ^ c.
  always_comb begin
    carry   = {g3, 1'b0};
    sumComb = p0 ^ carry[WIDTH-1:0];
    cout    = carry[WIDTH];
  end

`ifdef PIPELINE_REG_EN
  logic [WIDTH-1:0] aQ, aD;
  logic [WIDTH-1:0] bQ, bD;
  logic [WIDTH-1:0] sumQ, sumD;

  assign aD   = ui_in;
  assign bD   = uio_in;
  assign sumD = sumComb;

  // Operand stage, then sum stage. Reset clears both at once, dropping in-flight sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aQ   <= '0;
      bQ   <= '0;
      sumQ <= '0;
    end else begin
      aQ   <= aD;
      bQ   <= bD;
      sumQ <= sumD;
    end
  end

  assign opA    = aQ;
  assign opB    = bQ;
  assign uo_out = sumQ;
`else
  assign opA    = ui_in;
  assign opB    = uio_in;
  assign uo_out = sumComb;
`endif

  // All bidirectional pins are permanently inputs
  assign uio_out = '0;
  assign uio_oe  = '0;

  // Signals the design intentionally ignores: the slot enable, the dropped
  // carry-out, the top propagate, and the clock/reset in the combinational build
  logic unusedSink;
  assign unusedSink = &{1'b0, ena, cout, p3, clk, rst};

endmodule

// File: tb/tb_prefix8_adder.sv
// tb_prefix8_adder: scoreboard bench for prefix8_adder.
// The stimulus process pushes expected sums into a queue. A separate monitor
// pops each entry once its latency has elapsed and compares it with uo_out.
// The same bench covers both builds, with and without PIPELINE_REG_EN.
module tb_prefix8_adder;

`ifdef PIPELINE_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int PERIOD = 10;
  localparam int NUM_RANDOM = 1500;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    int         beat;
  } item_t;

  item_t scoreQ[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] uiIn;
  logic [7:0] uioIn;
  logic [7:0] uoOut;
  logic [7:0] uioOut;
  logic [7:0] uioOe;

  int compared   = 0;
  int mismatched = 0;
  bit monitorOn  = 1'b0;

  always #(PERIOD/2) clk = ~clk;

  prefix8_adder dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (uiIn),
    .uio_in (uioIn),
    .uo_out (uoOut),
    .uio_out(uioOut),
    .uio_oe (uioOe)
  );

  // Reference model: integer addition reduced modulo 256
  function automatic logic [7:0] refSum(input int a, input int b);
    return 8'((a + b) % 256);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  // Drive one operand pair on a falling edge and queue its expected sum
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    item_t it;
    @(negedge clk);
    uiIn  = a;
    uioIn = b;
    it.a    = a;
    it.b    = b;
    it.sum  = refSum(int'(a), int'(b));
    it.beat = int'($time / PERIOD);
    scoreQ.push_back(it);
  endtask

  // Monitor: 2 time units after each falling edge, pop the entry whose latency has elapsed
  initial begin : monitor
    int    nowBeat;
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (monitorOn && scoreQ.size() > 0) begin
        nowBeat = int'($time / PERIOD);
        if (scoreQ[0].beat + LAT == nowBeat) begin
          it = scoreQ.pop_front();
          checkOutput($sformatf("sum a=%02h b=%02h", it.a, it.b), uoOut, it.sum);
          checkOutput("uio_out", uioOut, 8'h00);
          checkOutput("uio_oe", uioOe, 8'h00);
        end else if (scoreQ[0].beat + LAT < nowBeat) begin
          it = scoreQ.pop_front();
          compared++;
          mismatched++;
          $display("[TB] FAIL missed a=%02h b=%02h: issued beat %0d, now beat %0d",
                   it.a, it.b, it.beat, nowBeat);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin : watchdog
    #(PERIOD * 50000);
    $display("[TB] FAIL timeout: simulation exceeded its cycle budget");
    $fatal(1, "[TB] timeout");
  end

  logic [7:0] dirA [7];
  logic [7:0] dirB [7];

  initial begin : stimulus
    dirA = '{8'h03, 8'hFF, 8'h7F, 8'h80, 8'hAA, 8'h00, 8'hFF};
    dirB = '{8'h05, 8'h01, 8'h01, 8'h80, 8'h55, 8'h00, 8'hFF};

    rst   = 1'b1;
    ena   = 1'b1;
    uiIn  = 8'h03;
    uioIn = 8'h05;
    #3;
`ifdef PIPELINE_REG_EN
    checkOutput("reset uo_out", uoOut, 8'h00);
`else
    checkOutput("reset uo_out", uoOut, 8'h08);
`endif
    checkOutput("reset uio_out", uioOut, 8'h00);
    checkOutput("reset uio_oe", uioOe, 8'h00);

    @(negedge clk);
    rst       = 1'b0;
    monitorOn = 1'b1;

    // Directed corner cases
    for (int i = 0; i < 7; i++) begin
      applyStimulus(dirA[i], dirB[i]);
    end

    // Random operand pairs, with ena toggled to show it has no effect
    for (int i = 0; i < NUM_RANDOM; i++) begin
      ena = 1'($urandom_range(0, 1));
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    ena = 1'b1;

    // Stream 0x10 + 0x20, then assert reset between clock edges
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h10, 8'h20);
    end
    #3;
    rst = 1'b1;
    #1;
`ifdef PIPELINE_REG_EN
    checkOutput("reset async", uoOut, 8'h00);
    scoreQ.delete();
    @(posedge clk);
    #1;
    checkOutput("reset held", uoOut, 8'h00);
`else
    checkOutput("reset ignored", uoOut, 8'h30);
    @(posedge clk);
    #1;
    checkOutput("reset held ignored", uoOut, 8'h30);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h10, 8'h20);
    end

    // Let the last entries reach the output, then confirm nothing remained unchecked
    repeat (LAT + 2) @(negedge clk);
    #3;
    checkOutput("queue drained", 8'(scoreQ.size()), 8'h00);
    monitorOn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
